// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the ROM read arbiter (optional round-robin build: ROM_ARB_RR_EN).
package rom_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_IF, S_MEM} state_t;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam int unsigned ROM_SIZE_DEF   = 256;
  localparam int unsigned STARVE_MAX_DEF = 4;
endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester and ROM-side signals of the ROM read arbiter; slave = arbiter, master = requesters/ROM.
interface rom_read_arbiter_if;
  logic        if_req;
  logic [30:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        mem_req;
  logic [30:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [30:0] rom_addr;
  logic [31:0] rom_data;

  modport slave (
    input  if_req, if_addr, mem_req, mem_addr, rom_data,
    output if_gnt, if_rvalid, if_rdata, if_err,
           mem_gnt, mem_rvalid, mem_rdata, mem_err, rom_addr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_addr, rom_data,
    input  if_gnt, if_rvalid, if_rdata, if_err,
           mem_gnt, mem_rvalid, mem_rdata, mem_err, rom_addr
  );
endinterface

// File: rtl/rom_arb_grant.sv
// Grant selection between IF and MEM with conflict history.
// ROM_ARB_RR_EN selects alternating conflicts; default is MEM priority with IF starvation forcing.
module rom_arb_grant
  import rom_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic mem_req,
  output logic if_gnt,
  output logic mem_gnt
);
  logic conflict;
  logic if_wins;

  assign conflict = if_req & mem_req;

`ifdef ROM_ARB_RR_EN
  // Id of the requester that won the most recent conflict; reset value lets MEM win first.
  logic last_winner;

  assign if_wins = (last_winner == REQ_MEM);

  always_ff @(posedge clk) begin
    if (reset)
      last_winner <= REQ_IF;
    else if (conflict)
      last_winner <= if_wins ? REQ_IF : REQ_MEM;
  end
`else
  logic [2:0] starve_cnt;

  assign if_wins = (starve_cnt == 3'(STARVE_MAX));

  // A MEM grant with IF still waiting is always a lost conflict for IF.
  always_ff @(posedge clk) begin
    if (reset || !if_req || if_gnt)
      starve_cnt <= '0;
    else if (mem_gnt && (starve_cnt < 3'(STARVE_MAX)))
      starve_cnt <= starve_cnt + 3'd1;
  end
`endif

  always_comb begin
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    if (!reset) begin
      if (conflict) begin
        if_gnt  = if_wins;
        mem_gnt = !if_wins;
      end else begin
        if_gnt  = if_req;
        mem_gnt = mem_req;
      end
    end
  end
endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one combinational ROM between fetch (IF) and memory-stage (MEM) reads, one-cycle latency.
// Build option ROM_ARB_RR_EN (in rom_arb_grant) alternates conflict winners.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ROM_SIZE   = ROM_SIZE_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  rom_read_arbiter_if.slave  bus
);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * ROM_SIZE);

  logic        if_gnt;
  logic        mem_gnt;
  state_t      state_q;
  state_t      state_d;
  logic [30:0] addr_sel;
  logic        err_sel;
  logic [31:0] word_sel;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_err_q;
  logic        mem_err_q;

  rom_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .clk     (clk),
    .reset   (reset),
    .if_req  (bus.if_req),
    .mem_req (bus.mem_req),
    .if_gnt  (if_gnt),
    .mem_gnt (mem_gnt)
  );

  always_comb begin
    addr_sel = '0;
    if (if_gnt)
      addr_sel = bus.if_addr;
    else if (mem_gnt)
      addr_sel = bus.mem_addr;
  end

  always_comb begin
    err_sel  = ({1'b0, addr_sel} >= ADDR_LIMIT) || (addr_sel[1:0] != 2'b00);
    word_sel = err_sel ? '0 : bus.rom_data;
  end

  always_comb begin
    state_d = S_IDLE;
    if (if_gnt)
      state_d = S_IF;
    else if (mem_gnt)
      state_d = S_MEM;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Each requester keeps its own word so the loser's rdata holds across the other's responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      mem_rdata_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      if (if_gnt) begin
        if_rdata_q <= word_sel;
        if_err_q   <= err_sel;
      end
      if (mem_gnt) begin
        mem_rdata_q <= word_sel;
        mem_err_q   <= err_sel;
      end
    end
  end

  // Gating with reset drops a response that would land in a reset cycle.
  assign bus.if_rvalid  = (state_q == S_IF)  && !reset;
  assign bus.mem_rvalid = (state_q == S_MEM) && !reset;
  assign bus.if_gnt     = if_gnt;
  assign bus.mem_gnt    = mem_gnt;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_err     = if_err_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_err    = mem_err_q;
  assign bus.rom_addr   = addr_sel;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter; build with ROM_ARB_RR_EN for the round-robin variant.
module tb_rom_read_arbiter;
  import rom_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_read_arbiter_if bus ();

  rom_read_arbiter #(.ROM_SIZE(256), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        is_mem;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] last_if_data = '0;
  logic [31:0] last_mem_data = '0;

  // ROM contents: word index i holds (i << 25) | (3 * i).
  function automatic logic [31:0] rom_word(input logic [30:0] a);
    logic [31:0] idx;
    idx = {24'h0, a[9:2]};
    return (idx << 25) | (idx * 32'd3);
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  function automatic resp_t make_resp(input logic is_mem, input logic [30:0] a, input int c);
    resp_t r;
    r.is_mem = is_mem;
    r.err    = (a >= 31'd1024) || (a[1:0] != 2'b00);
    r.data   = r.err ? 32'h0 : rom_word(a);
    r.cyc    = c;
    return r;
  endfunction

  // Response monitor: pops entries pushed in an earlier cycle.
  always @(negedge clk) begin
    resp_t e;
    if (reset) begin
      sb.delete();
      last_if_data  = '0;
      last_mem_data = '0;
      checks++;
      if (bus.if_rvalid !== 1'b0 || bus.mem_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_rvalid cyc=%0d: if_rvalid=%b mem_rvalid=%b, required 0 0",
                 cyc, bus.if_rvalid, bus.mem_rvalid);
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.is_mem) begin
        last_mem_data = e.data;
        if (bus.mem_rvalid !== 1'b1 || bus.if_rvalid !== 1'b0 || bus.mem_rdata !== e.data ||
            bus.mem_err !== e.err || bus.if_rdata !== last_if_data) begin
          errors++;
          $display("FAIL mem_resp cyc=%0d: rv=%b/%b rdata=%h err=%b if_rdata=%h, required 0/1 %h %b %h",
                   cyc, bus.if_rvalid, bus.mem_rvalid, bus.mem_rdata, bus.mem_err, bus.if_rdata,
                   e.data, e.err, last_if_data);
        end
      end else begin
        last_if_data = e.data;
        if (bus.if_rvalid !== 1'b1 || bus.mem_rvalid !== 1'b0 || bus.if_rdata !== e.data ||
            bus.if_err !== e.err || bus.mem_rdata !== last_mem_data) begin
          errors++;
          $display("FAIL if_resp cyc=%0d: rv=%b/%b rdata=%h err=%b mem_rdata=%h, required 1/0 %h %b %h",
                   cyc, bus.if_rvalid, bus.mem_rvalid, bus.if_rdata, bus.if_err, bus.mem_rdata,
                   e.data, e.err, last_mem_data);
        end
      end
    end else begin
      checks++;
      if (bus.if_rvalid !== 1'b0 || bus.mem_rvalid !== 1'b0 ||
          bus.if_rdata !== last_if_data || bus.mem_rdata !== last_mem_data) begin
        errors++;
        $display("FAIL idle_resp cyc=%0d: rv=%b/%b rdata=%h/%h, required 0/0 %h/%h",
                 cyc, bus.if_rvalid, bus.mem_rvalid, bus.if_rdata, bus.mem_rdata,
                 last_if_data, last_mem_data);
      end
    end
  end

  task automatic drive(input logic r, input logic iq, input logic [30:0] ia,
                       input logic mq, input logic [30:0] ma);
    @(posedge clk);
    #1;
    reset        = r;
    bus.if_req   = iq;
    bus.if_addr  = ia;
    bus.mem_req  = mq;
    bus.mem_addr = ma;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.mem_gnt, bus.if_rvalid, bus.mem_rvalid, bus.if_err, bus.mem_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: gnt=%b%b rvalid=%b%b err=%b%b, required all 0",
               bus.if_gnt, bus.mem_gnt, bus.if_rvalid, bus.mem_rvalid, bus.if_err, bus.mem_err);
    end
    checks++;
    if (bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0 || bus.rom_addr !== 31'h0) begin
      errors++;
      $display("FAIL reset_data: if_rdata=%h mem_rdata=%h rom_addr=%h, required 0 0 0",
               bus.if_rdata, bus.mem_rdata, bus.rom_addr);
    end
    checks++;
    if (dut.state_q !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d, required %0d", dut.state_q, S_IDLE);
    end
  endtask

  task automatic test_single_if();
    drive(1'b0, 1'b1, 31'h10, 1'b0, 31'h0);
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1 || bus.mem_gnt !== 1'b0 || bus.rom_addr !== 31'h10) begin
      errors++;
      $display("FAIL single_if_gnt: gnt=%b%b rom_addr=%h, required 10 00000010",
               bus.if_gnt, bus.mem_gnt, bus.rom_addr);
    end
    sb.push_back(make_resp(REQ_IF, 31'h10, cyc));
    drive(1'b0, 1'b0, 31'h0, 1'b0, 31'h0);
    @(negedge clk);
    #1;
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0800000c || bus.if_err !== 1'b0) begin
      errors++;
      $display("FAIL single_if_resp: rvalid=%b rdata=%h err=%b, required 1 0800000c 0",
               bus.if_rvalid, bus.if_rdata, bus.if_err);
    end
  endtask

  task automatic test_priority();
    logic [30:0] ia;
    logic [30:0] ma;
    logic        exp_if;
    ia = 31'h100;
    for (int i = 0; i < 10; i++) begin
      ma = 31'h200 + 31'(4 * i);
      drive(1'b0, 1'b1, ia, 1'b1, ma);
      #1;
`ifdef ROM_ARB_RR_EN
      exp_if = (i % 2) == 1;
`else
      exp_if = (i % 5) == 4;
`endif
      checks++;
      if (bus.if_gnt !== exp_if || bus.mem_gnt !== !exp_if || bus.rom_addr !== (exp_if ? ia : ma)) begin
        errors++;
        $display("FAIL priority[%0d]: gnt=%b%b rom_addr=%h, required %b%b %h",
                 i, bus.if_gnt, bus.mem_gnt, bus.rom_addr, exp_if, !exp_if, exp_if ? ia : ma);
      end
      sb.push_back(make_resp(exp_if ? REQ_IF : REQ_MEM, exp_if ? ia : ma, cyc));
      if (exp_if) ia = ia + 31'd4;
    end
    drive(1'b0, 1'b0, 31'h0, 1'b0, 31'h0);
  endtask

  task automatic test_errors();
    logic        is_mem [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [30:0] addr   [6] = '{31'h400, 31'h6, 31'h3fc, 31'h7ffffffc, 31'h3fe, 31'h0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, !is_mem[i], addr[i], is_mem[i], addr[i]);
      #1;
      checks++;
      if (bus.if_gnt !== !is_mem[i] || bus.mem_gnt !== is_mem[i] || bus.rom_addr !== addr[i]) begin
        errors++;
        $display("FAIL err_gnt[%0d]: gnt=%b%b rom_addr=%h, required %b%b %h",
                 i, bus.if_gnt, bus.mem_gnt, bus.rom_addr, !is_mem[i], is_mem[i], addr[i]);
      end
      sb.push_back(make_resp(is_mem[i], addr[i], cyc));
    end
    drive(1'b0, 1'b0, 31'h0, 1'b0, 31'h0);
  endtask

  task automatic test_back_to_back();
    logic [30:0] a;
    logic        m;
    for (int i = 0; i < 8; i++) begin
      a = {21'h0, 8'($urandom_range(0, 255)), 2'b00};
      m = (i % 3) != 0;
      drive(1'b0, !m, a, m, a);
      #1;
      checks++;
      if (bus.if_gnt !== !m || bus.mem_gnt !== m || bus.rom_addr !== a) begin
        errors++;
        $display("FAIL b2b_gnt[%0d]: gnt=%b%b rom_addr=%h, required %b%b %h",
                 i, bus.if_gnt, bus.mem_gnt, bus.rom_addr, !m, m, a);
      end
      sb.push_back(make_resp(m, a, cyc));
    end
    drive(1'b0, 1'b0, 31'h0, 1'b0, 31'h0);
  endtask

  task automatic test_reset_inflight();
    drive(1'b0, 1'b1, 31'h20, 1'b0, 31'h0);
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL inflight_gnt: if_gnt=%b, required 1", bus.if_gnt);
    end
    sb.push_back(make_resp(REQ_IF, 31'h20, cyc));
    drive(1'b1, 1'b1, 31'h24, 1'b1, 31'h28);
    #1;
    checks++;
    if (bus.if_gnt !== 1'b0 || bus.mem_gnt !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.mem_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL inflight_reset: gnt=%b%b rvalid=%b%b, required 00 00",
               bus.if_gnt, bus.mem_gnt, bus.if_rvalid, bus.mem_rvalid);
    end
    drive(1'b0, 1'b0, 31'h0, 1'b0, 31'h0);
    drive(1'b0, 1'b0, 31'h0, 1'b0, 31'h0);
  endtask

  initial begin
    test_reset();
    test_single_if();
    test_priority();
    test_errors();
    test_back_to_back();
    test_reset_inflight();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
